// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: handshake bundle between the pipeline datapath and the
// freeze/flush sequencer.
//   slave  modport (sequencer side): receives memReadMem, memWriteMem,
//          branchTaken, hazard; drives every stage-register control,
//          sramEn, memReady and the 16-bit stallCycles counter.
//   master modport (datapath side): the mirror image.
interface pipe_ctrl_if;
    logic        memReadMem;
    logic        memWriteMem;
    logic        branchTaken;
    logic        hazard;
    logic        pcFreeze;
    logic        ifidFreeze;
    logic        ifidFlush;
    logic        idexFreeze;
    logic        idexFlush;
    logic        exmemFreeze;
    logic        memwbFlush;
    logic        sramEn;
    logic        memReady;
    logic [15:0] stallCycles;

    modport master (
        output memReadMem, memWriteMem, branchTaken, hazard,
        input  pcFreeze, ifidFreeze, ifidFlush, idexFreeze, idexFlush,
               exmemFreeze, memwbFlush, sramEn, memReady, stallCycles
    );

    modport slave (
        input  memReadMem, memWriteMem, branchTaken, hazard,
        output pcFreeze, ifidFreeze, ifidFlush, idexFreeze, idexFlush,
               exmemFreeze, memwbFlush, sramEn, memReady, stallCycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central freeze/flush sequencer for a 5-stage pipeline.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - pipe_ctrl_if.slave: memory/branch/hazard requests in,
//          per-stage freeze/flush controls, SRAM handshake and the
//          saturating stall-cycle counter out.
// Priority of the controls: multi-cycle SRAM stall, then taken branch,
// then load-use hazard. All controls are combinational from state and
// inputs and are forced low while reset is held.
module pipe_ctrl #(
    parameter int WAIT_CYCLES = 4,
    parameter int CNT_W       = $clog2(WAIT_CYCLES) + 1
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam bit              MULTI    = (WAIT_CYCLES > 1);
    // The request cycle itself is the first wait cycle, so BUSY counts
    // down from WAIT_CYCLES-2 and releases the pipeline when it hits 0.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0);
    localparam logic [15:0]     STALL_MAX = 16'hFFFF;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic mem_req;
    logic mem_stall;
    logic mem_ready;
    logic sram_en;

    // Wait-state FSM next-state and stall/ready decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        mem_req   = bus.memReadMem | bus.memWriteMem;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        mem_ready = 1'b0;
        sram_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    sram_en = 1'b1;
                    if (MULTI) begin
                        mem_stall = 1'b1;
                        cnt_d     = CNT_LOAD;
                        state_d   = BUSY;
                    end else begin
                        // Single-cycle SRAM: ready in the request cycle.
                        mem_ready = 1'b1;
                    end
                end
            end
            BUSY: begin
                sram_en = 1'b1;
                if (cnt_q != '0) begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    mem_ready = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_cnt_d = (mem_stall && (stall_cnt_q != STALL_MAX)) ? stall_cnt_q + 16'd1
                                                                : stall_cnt_q;
    end

    // Stage-register controls. A memory stall freezes everything up to
    // EX/MEM and bubbles WB; branch/hazard stay pending because EX and ID
    // are frozen. A taken branch squashes ID, so it masks the hazard.
    always_comb begin
        bus.pcFreeze    = 1'b0;
        bus.ifidFreeze  = 1'b0;
        bus.ifidFlush   = 1'b0;
        bus.idexFreeze  = 1'b0;
        bus.idexFlush   = 1'b0;
        bus.exmemFreeze = 1'b0;
        bus.memwbFlush  = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                bus.pcFreeze    = 1'b1;
                bus.ifidFreeze  = 1'b1;
                bus.idexFreeze  = 1'b1;
                bus.exmemFreeze = 1'b1;
                bus.memwbFlush  = 1'b1;
            end else if (bus.branchTaken) begin
                bus.ifidFlush = 1'b1;
                bus.idexFlush = 1'b1;
            end else if (bus.hazard) begin
                bus.pcFreeze   = 1'b1;
                bus.ifidFreeze = 1'b1;
                bus.idexFlush  = 1'b1;
            end
        end
        bus.sramEn   = rst & sram_en;
        bus.memReady = rst & mem_ready;
    end

    assign bus.stallCycles = stall_cnt_q;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + randomized checking of pipe_ctrl against an
// access-age reference model. Three builds: WAIT_CYCLES=4 (main),
// WAIT_CYCLES=1 (single-cycle SRAM) and WAIT_CYCLES=70000 (saturation).
module tb_pipe_ctrl;

    logic clk;
    logic rst;

    pipe_ctrl_if ifm ();
    pipe_ctrl_if ifo ();
    pipe_ctrl_if ifb ();

    pipe_ctrl #(.WAIT_CYCLES(4))     dut_m (.clk(clk), .rst(rst), .bus(ifm.slave));
    pipe_ctrl #(.WAIT_CYCLES(1))     dut_o (.clk(clk), .rst(rst), .bus(ifo.slave));
    pipe_ctrl #(.WAIT_CYCLES(70000)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: index of the current cycle within an SRAM access
    // (-1 = no access in flight) and the expected stall counter.
    int age_m   = -1;
    int stall_m = 0;
    int age_o   = -1;

    logic [8:0] act_m, act_o;
    assign act_m = {ifm.pcFreeze, ifm.ifidFreeze, ifm.ifidFlush, ifm.idexFreeze,
                    ifm.idexFlush, ifm.exmemFreeze, ifm.memwbFlush, ifm.sramEn, ifm.memReady};
    assign act_o = {ifo.pcFreeze, ifo.ifidFreeze, ifo.ifidFlush, ifo.idexFreeze,
                    ifo.idexFlush, ifo.exmemFreeze, ifo.memwbFlush, ifo.sramEn, ifo.memReady};

    logic       r_mr, r_mw, r_br, r_hz;
    int         r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // An access starts in the cycle a request is seen with none in flight,
    // lasts w cycles, stalls the first w-1 and is ready on the last.
    function automatic int cur_age(input int age, input logic req);
        return (age < 0 && req) ? 0 : age;
    endfunction

    function automatic logic is_stall(input int w, input int age, input logic req);
        int a;
        a = cur_age(age, req);
        return (a >= 0) && (a < w - 1);
    endfunction

    function automatic int next_age(input int w, input int age, input logic req);
        int a;
        a = cur_age(age, req);
        if (a < 0 || a == w - 1) return -1;
        return a + 1;
    endfunction

    // Expected {pcF, ifidF, ifidC, idexF, idexC, exmemF, memwbC, sramEn, memReady}.
    function automatic logic [8:0] exp_ctrl(input int w, input int age, input logic rn,
                                            input logic mr, mw, br, hz);
        logic req, stall, ready, sram;
        int   a;
        req   = mr | mw;
        a     = cur_age(age, req);
        stall = is_stall(w, age, req);
        ready = (a >= 0) && (a == w - 1);
        sram  = (a >= 0);
        if (!rn)   return 9'b0;
        if (stall) return {7'b1101011, sram, ready};
        if (br)    return {7'b0010100, sram, ready};
        if (hz)    return {7'b1100100, sram, ready};
        return {7'b0, sram, ready};
    endfunction

    // One main-build cycle: drive at negedge, check mid-low-phase, advance
    // the model across the rising edge, return at the next negedge.
    task automatic cyc(input logic mr, mw, br, hz);
        ifm.memReadMem  = mr;
        ifm.memWriteMem = mw;
        ifm.branchTaken = br;
        ifm.hazard      = hz;
        #1;
        check("ctrl_w4", {23'b0, act_m}, {23'b0, exp_ctrl(4, age_m, rst, mr, mw, br, hz)});
        check("stall_w4", {16'b0, ifm.stallCycles}, stall_m);
        @(posedge clk);
        if (rst) begin
            if (is_stall(4, age_m, mr | mw) && stall_m < 65535) stall_m++;
            age_m = next_age(4, age_m, mr | mw);
        end
        @(negedge clk);
    endtask

    task automatic cyc1(input logic mr, mw, br, hz);
        ifo.memReadMem  = mr;
        ifo.memWriteMem = mw;
        ifo.branchTaken = br;
        ifo.hazard      = hz;
        #1;
        check("ctrl_w1", {23'b0, act_o}, {23'b0, exp_ctrl(1, age_o, rst, mr, mw, br, hz)});
        check("stall_w1", {16'b0, ifo.stallCycles}, 0);
        @(posedge clk);
        if (rst) age_o = next_age(1, age_o, mr | mw);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        {ifm.memReadMem, ifm.memWriteMem, ifm.branchTaken, ifm.hazard} = 4'b0;
        {ifo.memReadMem, ifo.memWriteMem, ifo.branchTaken, ifo.hazard} = 4'b0;
        {ifb.memReadMem, ifb.memWriteMem, ifb.branchTaken, ifb.hazard} = 4'b0;
        @(negedge clk);

        // Reset held with active requests: everything low.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_pcFreeze", {31'b0, ifm.pcFreeze}, 0);

        // Release reset with a load pending: stall in the same cycle.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("single_load_stalls", {16'b0, ifm.stallCycles}, 3);

        // Store with a taken branch: flushes only on the ready cycle.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("store_branch_stalls", {16'b0, ifm.stallCycles}, 6);

        // Hazard alone, then hazard masked by a branch.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back loads: second access starts in cycle 4.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("b2b_stalls", {16'b0, ifm.stallCycles}, 12);

        // Third access, reset pulled in its second cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rst     = 1'b0;
        age_m   = -1;
        stall_m = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst_cnt", {16'b0, ifm.stallCycles}, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic on the main build.
        for (int i = 0; i < 400; i++) begin
            r    = int'($urandom_range(0, 9));
            r_mr = (r < 2);
            r_mw = (r == 2);
            r_br = ($urandom_range(0, 3) == 0);
            r_hz = ($urandom_range(0, 3) == 0);
            cyc(r_mr, r_mw, r_br, r_hz);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Single-cycle SRAM build: ready immediately, never a freeze.
        cyc1(1'b1, 1'b0, 1'b0, 1'b0);
        cyc1(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            r_mr = ($urandom_range(0, 2) == 0);
            r_mw = ($urandom_range(0, 4) == 0);
            r_br = ($urandom_range(0, 3) == 0);
            r_hz = ($urandom_range(0, 3) == 0);
            cyc1(r_mr, r_mw, r_br, r_hz);
        end

        // Saturation: one access long enough for >65535 stall cycles.
        ifb.memReadMem = 1'b1;
        repeat (65545) @(posedge clk);
        #2;
        check("sat_cnt", {16'b0, ifb.stallCycles}, 32'hFFFF);
        check("sat_still_stalled", {31'b0, ifb.pcFreeze}, 1);
        repeat (5) @(posedge clk);
        #2;
        check("sat_hold", {16'b0, ifb.stallCycles}, 32'hFFFF);
        check("sat_no_ready", {31'b0, ifb.memReady}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
